// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundles the hazard-control signals between the SimpleRISC pipeline and the
// central hazard controller.
//   master : pipeline side. Drives the hazard-detection inputs and receives the
//            stall/flush/bubble strobes.
//   slave  : pipe_hazard_ctrl side.
// Inputs to the controller:
//   RP1_OF, RP2_OF, useRP1_OF, useRP2_OF  - OF-stage source operands
//   is_Ld_ALU, isWb_ALU, rd_ALU           - ALU-stage destination info
//   isBranchTaken_ALU, mc_start_ALU       - ALU-stage branch / multi-cycle op
// Outputs from the controller:
//   stall_PC, stall_IFOF, stall_OFALU, flush_IFOF, flush_OFALU,
//   bubble_ALUMA, mc_busy
//   stall_cycles, flush_events            - present only with HAZARD_PERF_CNT_EN
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
  logic [4:0]  RP1_OF;
  logic [4:0]  RP2_OF;
  logic        useRP1_OF;
  logic        useRP2_OF;
  logic        is_Ld_ALU;
  logic        isWb_ALU;
  logic [4:0]  rd_ALU;
  logic        isBranchTaken_ALU;
  logic        mc_start_ALU;

  logic        stall_PC;
  logic        stall_IFOF;
  logic        stall_OFALU;
  logic        flush_IFOF;
  logic        flush_OFALU;
  logic        bubble_ALUMA;
  logic        mc_busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_events;

  modport master (
    output RP1_OF, RP2_OF, useRP1_OF, useRP2_OF, is_Ld_ALU, isWb_ALU, rd_ALU,
           isBranchTaken_ALU, mc_start_ALU,
    input  stall_PC, stall_IFOF, stall_OFALU, flush_IFOF, flush_OFALU,
           bubble_ALUMA, mc_busy, stall_cycles, flush_events
  );

  modport slave (
    input  RP1_OF, RP2_OF, useRP1_OF, useRP2_OF, is_Ld_ALU, isWb_ALU, rd_ALU,
           isBranchTaken_ALU, mc_start_ALU,
    output stall_PC, stall_IFOF, stall_OFALU, flush_IFOF, flush_OFALU,
           bubble_ALUMA, mc_busy, stall_cycles, flush_events
  );
`else
  modport master (
    output RP1_OF, RP2_OF, useRP1_OF, useRP2_OF, is_Ld_ALU, isWb_ALU, rd_ALU,
           isBranchTaken_ALU, mc_start_ALU,
    input  stall_PC, stall_IFOF, stall_OFALU, flush_IFOF, flush_OFALU,
           bubble_ALUMA, mc_busy
  );

  modport slave (
    input  RP1_OF, RP2_OF, useRP1_OF, useRP2_OF, is_Ld_ALU, isWb_ALU, rd_ALU,
           isBranchTaken_ALU, mc_start_ALU,
    output stall_PC, stall_IFOF, stall_OFALU, flush_IFOF, flush_OFALU,
           bubble_ALUMA, mc_busy
  );
`endif
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush control for the five-stage SimpleRISC pipeline.
// Handles load-use hazards, taken-branch squashes and multi-cycle ALU ops
// (mul/div/mod) that occupy the ALU stage for MC_LATENCY cycles.
// Ports:
//   clk    - pipeline clock, rising edge
//   rst_n  - asynchronous active-low reset
//   hz     - pipe_hazard_ctrl_if.slave (hazard inputs, stall/flush outputs)
// Parameter:
//   MC_LATENCY - cycles a multi-cycle op occupies ALU (2..16)
// Optional feature macro: HAZARD_PERF_CNT_EN adds saturating stall_cycles and
// flush_events performance counters.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MC_LATENCY = 4
) (
  input logic              clk,
  input logic              rst_n,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  // BUSY covers the stall cycles after the first one; the first stall cycle is
  // spent in IDLE and the final non-stall cycle in DONE.
  localparam int         CNT_INIT_I = (MC_LATENCY > 2) ? (MC_LATENCY - 3) : 0;
  localparam logic [3:0] CNT_INIT   = 4'(CNT_INIT_I);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic lu, mc;
  logic stall_pc, stall_ifof, stall_ofalu, flush_ifof, flush_ofalu, bubble;

  // ---- state register -------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---- next-state logic -----------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (hz.mc_start_ALU) begin
          if (MC_LATENCY == 2) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      // mc_start_ALU is still high for the same instruction here; ignoring it
      // prevents a retrigger.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- hazard detection and output priority ---------------------------------
  always_comb begin
    lu = hz.is_Ld_ALU & hz.isWb_ALU &
         ((hz.useRP1_OF & (hz.RP1_OF == hz.rd_ALU)) |
          (hz.useRP2_OF & (hz.RP2_OF == hz.rd_ALU)));
    mc = ((state_q == IDLE) & hz.mc_start_ALU) | (state_q == BUSY);

    stall_pc    = 1'b0;
    stall_ifof  = 1'b0;
    stall_ofalu = 1'b0;
    flush_ifof  = 1'b0;
    flush_ofalu = 1'b0;
    bubble      = 1'b0;

    // Outputs are gated by rst_n so they drop immediately on reset even when
    // the hazard inputs are still active.
    if (!rst_n) begin
      stall_pc = 1'b0;
    end else if (mc) begin
      stall_pc    = 1'b1;
      stall_ifof  = 1'b1;
      stall_ofalu = 1'b1;
      bubble      = 1'b1;
    end else if (hz.isBranchTaken_ALU) begin
      // The OF instruction is on the wrong path, so a load-use match is moot.
      flush_ifof  = 1'b1;
      flush_ofalu = 1'b1;
    end else if (lu) begin
      // OF/ALU is not held: the load moves on to MA while a NOP enters ALU.
      stall_pc    = 1'b1;
      stall_ifof  = 1'b1;
      flush_ofalu = 1'b1;
    end
  end

  assign hz.stall_PC     = stall_pc;
  assign hz.stall_IFOF   = stall_ifof;
  assign hz.stall_OFALU  = stall_ofalu;
  assign hz.flush_IFOF   = flush_ifof;
  assign hz.flush_OFALU  = flush_ofalu;
  assign hz.bubble_ALUMA = bubble;
  assign hz.mc_busy      = (state_q != IDLE);

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cycles_q, flush_events_q;

  // ---- saturating performance counters --------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= 16'd0;
      flush_events_q <= 16'd0;
    end else begin
      if (stall_pc && (stall_cycles_q != 16'hFFFF))
        stall_cycles_q <= stall_cycles_q + 16'd1;
      if (flush_ifof && (flush_events_q != 16'hFFFF))
        flush_events_q <= flush_events_q + 16'd1;
    end
  end

  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Drives two controllers (MC_LATENCY=4 and MC_LATENCY=2) with identical inputs
// and compares them against a cycle-count reference model.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hzA ();
  pipe_hazard_ctrl_if hzB ();

  pipe_hazard_ctrl #(.MC_LATENCY(4)) dutA (.clk(clk), .rst_n(rst_n), .hz(hzA));
  pipe_hazard_ctrl #(.MC_LATENCY(2)) dutB (.clk(clk), .rst_n(rst_n), .hz(hzB));

  int n_cmp = 0;
  int n_bad = 0;

  // Current stimulus values (mirrored onto both interfaces).
  logic [4:0] in_rp1, in_rp2, in_rd;
  logic       in_u1, in_u2, in_ld, in_wb, in_br, in_mc;

  // Reference model: occ = cycles already spent inside the current multi-cycle
  // op (0 = none in progress). Counters track stall / flush cycles of dutA.
  int occA, occB;
  int sc, fe;

  task automatic set_in(input logic [4:0] rp1, input logic [4:0] rp2,
                        input logic u1, input logic u2, input logic ld,
                        input logic wb, input logic [4:0] rd, input logic br,
                        input logic mcs);
    in_rp1 = rp1; in_rp2 = rp2; in_u1 = u1; in_u2 = u2; in_ld = ld;
    in_wb = wb; in_rd = rd; in_br = br; in_mc = mcs;
    hzA.RP1_OF = rp1; hzA.RP2_OF = rp2; hzA.useRP1_OF = u1; hzA.useRP2_OF = u2;
    hzA.is_Ld_ALU = ld; hzA.isWb_ALU = wb; hzA.rd_ALU = rd;
    hzA.isBranchTaken_ALU = br; hzA.mc_start_ALU = mcs;
    hzB.RP1_OF = rp1; hzB.RP2_OF = rp2; hzB.useRP1_OF = u1; hzB.useRP2_OF = u2;
    hzB.is_Ld_ALU = ld; hzB.isWb_ALU = wb; hzB.rd_ALU = rd;
    hzB.isBranchTaken_ALU = br; hzB.mc_start_ALU = mcs;
  endtask

  // {stall_PC, stall_IFOF, stall_OFALU, flush_IFOF, flush_OFALU, bubble, busy}
  function automatic logic [6:0] exp_out(input int occ, input int L,
                                         input logic rstn);
    logic lu, mcv, busy;
    if (!rstn) return 7'b0;
    lu   = in_ld && in_wb && ((in_u1 && in_rp1 == in_rd) ||
                              (in_u2 && in_rp2 == in_rd));
    mcv  = (occ == 0 && in_mc) || (occ > 0 && occ < L - 1);
    busy = (occ != 0);
    if (mcv)   return {6'b111_00_1, busy};
    if (in_br) return {6'b000_11_0, busy};
    if (lu)    return {6'b110_01_0, busy};
    return {6'b0, busy};
  endfunction

  function automatic int next_occ(input int occ, input int L);
    if (occ == 0)      return in_mc ? 1 : 0;
    if (occ >= L - 1)  return 0;
    return occ + 1;
  endfunction

  function automatic logic [6:0] obsA();
    return {hzA.stall_PC, hzA.stall_IFOF, hzA.stall_OFALU, hzA.flush_IFOF,
            hzA.flush_OFALU, hzA.bubble_ALUMA, hzA.mc_busy};
  endfunction

  function automatic logic [6:0] obsB();
    return {hzB.stall_PC, hzB.stall_IFOF, hzB.stall_OFALU, hzB.flush_IFOF,
            hzB.flush_OFALU, hzB.bubble_ALUMA, hzB.mc_busy};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare both DUTs (and counters) against the model in the current cycle.
  task automatic check_now(input string tag);
    chk({tag, "_L4"}, {9'b0, obsA()}, {9'b0, exp_out(occA, 4, rst_n)});
    chk({tag, "_L2"}, {9'b0, obsB()}, {9'b0, exp_out(occB, 2, rst_n)});
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, "_stall_cycles"}, hzA.stall_cycles, 16'(sc));
    chk({tag, "_flush_events"}, hzA.flush_events, 16'(fe));
`endif
  endtask

  // Advance one clock and the model with it; returns 1 ns after the edge.
  task automatic advance();
    logic [6:0] ea;
    ea = exp_out(occA, 4, rst_n);
    @(posedge clk);
    if (rst_n) begin
      if (ea[6] && sc < 65535) sc++;
      if (ea[3] && fe < 65535) fe++;
      occA = next_occ(occA, 4);
      occB = next_occ(occB, 2);
    end
    #1;
  endtask

  task automatic step(input string tag);
    #2;
    check_now(tag);
    advance();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    occA = 0; occB = 0; sc = 0; fe = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [6:0] mc_stall_tbl [5];
  logic [6:0] mc_busy_tbl  [5];

  initial begin
    mc_stall_tbl = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    mc_busy_tbl  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    do_reset();

    // Reset state with idle inputs.
    #2;
    chk("reset_idle_L4", {9'b0, obsA()}, 16'd0);
    check_now("reset_idle");
    advance();

    // Load-use on RP2, then the load has left ALU.
    set_in(5'd3, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    #2;
    chk("lu_const", {9'b0, obsA()}, {9'b0, 7'b110_01_0_0});
    check_now("lu");
    advance();
    set_in(5'd3, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0, 1'b0);
    step("lu_after");
    // Same match but RP2 not used: no stall.
    set_in(5'd3, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    #2;
    chk("lu_unused_const", {9'b0, obsA()}, 16'd0);
    check_now("lu_unused");
    advance();
    // Register 0 matches too; load without writeback does not.
    set_in(5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    step("lu_r0");
    set_in(5'd4, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0);
    step("lu_nowb");

    // Branch over an active load-use.
    set_in(5'd6, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    #2;
    chk("br_over_lu_const", {9'b0, obsA()}, {9'b0, 7'b000_11_0_0});
    check_now("br_over_lu");
    advance();

    // Multi-cycle op held for 4 cycles, then released.
    for (int i = 0; i < 5; i++) begin
      set_in(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 1'b0, (i < 4));
      #2;
      chk($sformatf("mc4_stall_c%0d", i), {15'b0, hzA.stall_PC},
          {15'b0, mc_stall_tbl[i][0]});
      chk($sformatf("mc4_busy_c%0d", i), {15'b0, hzA.mc_busy},
          {15'b0, mc_busy_tbl[i][0]});
      check_now($sformatf("mc_c%0d", i));
      advance();
    end

    // Multi-cycle start together with a taken branch: no flush.
    set_in(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1);
    #2;
    chk("mc_br_const", {9'b0, obsA()}, {9'b0, 7'b111_00_1_0});
    check_now("mc_br");
    advance();

    // Reset in BUSY with cnt=1 (one cycle into the op), hazards active.
    set_in(5'd6, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b1);
    do_reset();
    set_in(5'd6, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b1);
    step("mc_start_rst");
    #2;
    rst_n = 1'b0;
    occA = 0; occB = 0; sc = 0; fe = 0;
    #1;
    chk("async_rst_L4", {9'b0, obsA()}, 16'd0);
    chk("async_rst_L2", {9'b0, obsB()}, 16'd0);
    check_now("async_rst");
    @(posedge clk);
    #1;
    set_in(5'd6, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0);
    rst_n = 1'b1;
    #2;
    chk("post_rst_idle", {15'b0, hzA.mc_busy}, 16'd0);
    check_now("post_rst");
    advance();

`ifdef HAZARD_PERF_CNT_EN
    // 3 load-use stalls, 2 branch flushes, one 4-cycle op.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(5'd8, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
      step("perf_lu");
      set_in(5'd8, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0);
      step("perf_gap");
    end
    for (int i = 0; i < 2; i++) begin
      set_in(5'd8, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0);
      step("perf_br");
    end
    for (int i = 0; i < 5; i++) begin
      set_in(5'd8, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0, (i < 4));
      step("perf_mc");
    end
    chk("perf_stall_6", hzA.stall_cycles, 16'd6);
    chk("perf_flush_2", hzA.flush_events, 16'd2);
    // Continuous load-use to drive the stall counter into saturation.
    set_in(5'd8, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) advance();
    chk("perf_sat", hzA.stall_cycles, 16'hFFFF);
    check_now("perf_sat_model");
`endif

    // Randomised traffic with small register indices to make matches likely.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0));
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline control for the five-stage SimpleRISC pipeline (IF, OF, ALU, MA, RW). It generates the stall and flush strobes for the PC and the IF/OF and OF/ALU pipeline registers, plus a bubble strobe for ALU/MA. It handles three cases: load-use hazards, taken-branch squashes, and multi-cycle ALU operations (mul/div/mod) that hold the ALU stage for a fixed number of cycles. It sits beside the pipeline registers and drives their `stall_*` and `flush` inputs directly.

## Interface
- `MC_LATENCY`, default 4: total cycles a multi-cycle op occupies the ALU stage. Legal range 2..16.
- `clk  in  1`: pipeline clock, rising-edge.
- `rst_n  in  1`: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `RP1_OF`, `RP2_OF`  in  5 each: source register indices of the instruction in OF.
- `useRP1_OF`, `useRP2_OF`  in  1 each: the OF instruction actually reads RP1 / RP2.
- `is_Ld_ALU`  in  1: the instruction in ALU is a load.
- `isWb_ALU`  in  1: the ALU instruction writes back.
- `rd_ALU`  in  5: destination register index of the ALU instruction.
- `isBranchTaken_ALU`  in  1: branch resolved taken in ALU this cycle.
- `mc_start_ALU`  in  1: the ALU instruction is a multi-cycle op. Held high while that instruction sits in ALU.
- `stall_PC`, `stall_IFOF`, `stall_OFALU`  out  1 each: hold the PC / the IF/OF register / the OF/ALU register.
- `flush_IFOF`, `flush_OFALU`  out  1 each: load a NOP into the IF/OF / OF/ALU register.
- `bubble_ALUMA`  out  1: load a NOP into ALU/MA.
- `mc_busy`  out  1: the FSM is not IDLE.
- `stall_cycles`  out  16: performance counter, present only with `HAZARD_PERF_CNT_EN`.
- `flush_events`  out  16: performance counter, present only with `HAZARD_PERF_CNT_EN`.

## Operation
**Load-use detection (LU), combinational.** LU = `is_Ld_ALU & isWb_ALU & ((useRP1_OF & RP1_OF==rd_ALU) | (useRP2_OF & RP2_OF==rd_ALU))`. Register 0 gets no exception.

**Multi-cycle FSM, registered.** States IDLE, BUSY, DONE; 4-bit down-counter `cnt`.
- IDLE with `mc_start_ALU`:
  - `MC_LATENCY==2`: go to DONE.
  - Otherwise: go to BUSY and load `cnt = MC_LATENCY-3`.
- BUSY:
  - `cnt==0`: go to DONE.
  - Otherwise: decrement `cnt`.
- DONE: go to IDLE unconditionally. `mc_start_ALU` is ignored in DONE, which prevents a retrigger by the same instruction.
- MC = (IDLE & `mc_start_ALU`) | BUSY.

**Output priority, highest first.**
1. MC: `stall_PC`, `stall_IFOF`, `stall_OFALU`, `bubble_ALUMA` = 1; both flushes = 0. `isBranchTaken_ALU` and LU are ignored.
2. `isBranchTaken_ALU`: `flush_IFOF` = `flush_OFALU` = 1; all stalls = 0. This overrides LU, because the OF instruction is on the wrong path.
3. LU: `stall_PC` = `stall_IFOF` = 1 and `flush_OFALU` = 1. `stall_OFALU` = 0, so the bubble enters ALU while the load advances to MA.
4. Otherwise: all outputs 0.

`mc_busy` = (state != IDLE).

## Timing
- Stall, flush and bubble outputs are combinational from the inputs and the current state. They are valid in the same cycle so the pipeline registers sample them at the next `posedge clk`.
- The FSM state and `cnt` update on `posedge clk`.
- A multi-cycle op asserts stalls for exactly `MC_LATENCY-1` consecutive cycles, starting in the cycle `mc_start_ALU` is first seen in IDLE. The following cycle (DONE) has no stall, so ALU/MA captures the result.
- A load-use hazard stalls exactly 1 cycle. In the next cycle the load is in MA, so LU deasserts.
- A branch flush lasts 1 cycle per `isBranchTaken_ALU` cycle.
- **Reset:** `rst_n` low forces state = IDLE, `cnt` = 0, both counters = 0, and every output = 0 immediately, without waiting for `clk`. Reset during BUSY abandons the op; after release the FSM is IDLE and sees `mc_start_ALU` afresh.
- `mc_start_ALU` and `isBranchTaken_ALU` asserted together in IDLE: MC priority applies, so no flush is issued.

## Configuration
- Macro: `HAZARD_PERF_CNT_EN`.
- **Defined:**
  - `stall_cycles` increments each cycle `stall_PC`=1.
  - `flush_events` increments each cycle `flush_IFOF`=1.
  - Both saturate at 16'hFFFF and clear only on reset.
- **Undefined:** both ports and their counters are absent. All other behaviour is identical.

## Test plan
- Load-use: `is_Ld_ALU`=1, `isWb_ALU`=1, `rd_ALU`=5, `RP2_OF`=5, `useRP2_OF`=1 for one cycle. Required: `stall_PC`=`stall_IFOF`=`flush_OFALU`=1 and `stall_OFALU`=0 that cycle; all 0 the next cycle once the load has left ALU. Repeat with `useRP2_OF`=0: no stall.
- Branch over load-use: `isBranchTaken_ALU`=1 together with an active LU match. Required: `flush_IFOF`=`flush_OFALU`=1 and every stall = 0.
- Multi-cycle, `MC_LATENCY`=4: `mc_start_ALU` held high for 4 cycles. Required: stalls and `bubble_ALUMA` = 1 in cycles 0–2 and 0 in cycle 3; `mc_busy` = 1 in cycles 1–3; FSM back in IDLE in cycle 4 with no retrigger.
- `MC_LATENCY`=2: `mc_start_ALU` high for 2 cycles. Required: exactly 1 stall cycle, then DONE, then IDLE.
- Reset mid-op: drop `rst_n` in BUSY with `cnt`=1. Required: all outputs 0 asynchronously; after release with `mc_start_ALU`=0, state = IDLE.
- With `HAZARD_PERF_CNT_EN`: 3 load-use stalls, 2 branch flushes and one 4-cycle multi-cycle op. Required: `stall_cycles`=6, `flush_events`=2. Preload near 16'hFFFF to check saturation.
